// File: rtl/unsigned_array_multiplier_pipelined.sv
// Pipelined unsigned array multiplier with a valid/ready handshake and a global stall.
// Optional macro UNSIGNED_ARRAY_MULTIPLIER_TRISTATE_OUT_EN floats the result while disabled.
module unsigned_array_multiplier_pipelined #(
  parameter int DATA_WIDTH     = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic                    Clock_In,
  input  logic                    Reset_In,
  input  logic                    Enable_In,
  input  logic [DATA_WIDTH-1:0]   Data_A_In,
  input  logic [DATA_WIDTH-1:0]   Data_B_In,
  input  logic                    Valid_In,
  output logic                    Ready_Out,
  output logic [2*DATA_WIDTH-1:0] Multiplied_Result_Out,
  output logic                    Valid_Out,
  input  logic                    Ready_In
);

  localparam int NUM_STAGES =
    (DATA_WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;
  localparam int PW = 2 * DATA_WIDTH;

  logic w_advance;

  assign w_advance = Enable_In && (!Valid_Out || Ready_In);
  assign Ready_Out = w_advance;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO = k * ROWS_PER_STAGE;
    localparam int HI = (LO + ROWS_PER_STAGE > DATA_WIDTH) ?
                        DATA_WIDTH : LO + ROWS_PER_STAGE;

    logic                  w_in_vld;
    logic [DATA_WIDTH-1:0] w_in_a;
    logic [DATA_WIDTH-1:0] w_in_b;
    logic [PW-1:0]         w_in_sum;
    logic [PW-1:0]         w_sum;
    logic                  r_vld;
    logic [PW-1:0]         r_sum;

    if (k == 0) begin : g_src
      assign w_in_vld = Valid_In;
      assign w_in_a   = Data_A_In;
      assign w_in_b   = Data_B_In;
      assign w_in_sum = '0;
    end else begin : g_src
      assign w_in_vld = g_stage[k-1].r_vld;
      assign w_in_a   = g_stage[k-1].g_ab.r_a;
      assign w_in_b   = g_stage[k-1].g_ab.r_b;
      assign w_in_sum = g_stage[k-1].r_sum;
    end

    // Only this stage's rows [LO, HI) are added; the rest pass through.
    always_comb begin
      w_sum = w_in_sum;
      for (int j = 0; j < DATA_WIDTH; j++) begin
        if (j >= LO && j < HI && w_in_b[j])
          w_sum = w_sum + (PW'(w_in_a) << j);
      end
    end

    // Operands are only needed by later stages, so the last one drops them.
    if (k < NUM_STAGES - 1) begin : g_ab
      logic [DATA_WIDTH-1:0] r_a;
      logic [DATA_WIDTH-1:0] r_b;

      always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance && w_in_vld) begin
          r_a <= w_in_a;
          r_b <= w_in_b;
        end
      end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
      if (Reset_In) begin
        r_vld <= 1'b0;
        r_sum <= '0;
      end else if (w_advance) begin
        r_vld <= w_in_vld;
        if (w_in_vld)
          r_sum <= w_sum;
      end
    end
  end

  assign Valid_Out = g_stage[NUM_STAGES-1].r_vld;

`ifdef UNSIGNED_ARRAY_MULTIPLIER_TRISTATE_OUT_EN
  assign Multiplied_Result_Out = Enable_In ?
    g_stage[NUM_STAGES-1].r_sum : {PW{1'bz}};
`else
  assign Multiplied_Result_Out = g_stage[NUM_STAGES-1].r_sum;
`endif

endmodule

// File: tb/tb_unsigned_array_multiplier_pipelined.sv
// Scoreboard bench for unsigned_array_multiplier_pipelined.
// Covers latency, streaming, backpressure, reset flush and enable freeze.
module tb_unsigned_array_multiplier_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        vin;
  logic        rdy_in;
  logic [7:0]  a;
  logic [7:0]  b;
  wire         rdy_out;
  wire         vout;
  wire  [15:0] res;

  logic        vin3;
  logic        rdy_in3;
  logic [7:0]  a3;
  logic [7:0]  b3;
  wire         rdy3;
  wire         vout3;
  wire  [15:0] res3;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  unsigned_array_multiplier_pipelined #(
    .DATA_WIDTH(8), .ROWS_PER_STAGE(2)
  ) u_dut (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en),
    .Data_A_In(a), .Data_B_In(b), .Valid_In(vin),
    .Ready_Out(rdy_out), .Multiplied_Result_Out(res),
    .Valid_Out(vout), .Ready_In(rdy_in)
  );

  unsigned_array_multiplier_pipelined #(
    .DATA_WIDTH(8), .ROWS_PER_STAGE(3)
  ) u_dut3 (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en),
    .Data_A_In(a3), .Data_B_In(b3), .Valid_In(vin3),
    .Ready_Out(rdy3), .Multiplied_Result_Out(res3),
    .Valid_Out(vout3), .Ready_In(rdy_in3)
  );

  // Output transfer happens at the next rising edge; compare now.
  always @(negedge clk) begin
    if (!rst && en && vout && rdy_in) begin
      logic [15:0] exp;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got %0d want none", res);
      end else begin
        exp = q.pop_front();
        if (res !== exp) begin
          errors++;
          $display("FAIL sb_result got %0d want %0d", res, exp);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] x,
                       input logic [7:0] y);
    vin = v;
    a   = x;
    b   = y;
    @(negedge clk);
    if (v && rdy_out) q.push_back(16'(x) * 16'(y));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    vin = 1'b0;
    while (q.size() != 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain left %0d want 0", nm, q.size());
    end
    q.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (vout !== 1'b0 || res !== 16'd0) begin
      errors++;
      $display("FAIL reset_state vout=%b res=%0d want 0/0", vout, res);
    end
    checks++;
    if (vout3 !== 1'b0 || res3 !== 16'd0) begin
      errors++;
      $display("FAIL reset_state3 vout=%b res=%0d want 0/0", vout3, res3);
    end
    checks++;
    if (rdy_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", rdy_out);
    end
    en = 1'b0;
    #1;
    checks++;
    if (rdy_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_en0 got %b want 0", rdy_out);
    end
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    drive(1'b1, 8'd255, 8'd255);
    vin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (vout !== (i == 3)) begin
        errors++;
        $display("FAIL single_valid cyc %0d got %b want %b", i, vout, i == 3);
      end
      if (i >= 3) begin
        checks++;
        if (res !== 16'hFE01) begin
          errors++;
          $display("FAIL single_result cyc %0d got %h want fe01", i, res);
        end
      end
      @(posedge clk);
      #1;
    end
    drain("single");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [4] = '{16'd15, 16'd0, 16'd256, 16'd255};
    drive(1'b1, 8'd3, 8'd5);
    drive(1'b1, 8'd0, 8'd200);
    drive(1'b1, 8'd128, 8'd2);
    drive(1'b1, 8'd17, 8'd15);
    vin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (vout !== (i < 4)) begin
        errors++;
        $display("FAIL b2b_valid cyc %0d got %b want %b", i, vout, i < 4);
      end else if (i < 4 && res !== exp[i]) begin
        errors++;
        $display("FAIL b2b_result cyc %0d got %0d want %0d", i, res, exp[i]);
      end
      @(posedge clk);
      #1;
    end
    drain("b2b");
  endtask

  task automatic test_backpressure();
    drive(1'b1, 8'd3, 8'd5);
    drive(1'b1, 8'd0, 8'd200);
    drive(1'b1, 8'd128, 8'd2);
    drive(1'b1, 8'd17, 8'd15);
    vin    = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (vout !== 1'b1 || res !== 16'd15 || rdy_out !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d v=%b res=%0d rdy=%b want 1/15/0",
                 i, vout, res, rdy_out);
      end
      @(posedge clk);
      #1;
    end
    rdy_in = 1'b1;
    drain("bp");
    @(negedge clk);
    checks++;
    if (vout !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle vout got %b want 0", vout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rows3();
    vin3 = 1'b1;
    a3   = 8'hAB;
    b3   = 8'hCD;
    @(negedge clk);
    checks++;
    if (rdy3 !== 1'b1) begin
      errors++;
      $display("FAIL rows3_ready got %b want 1", rdy3);
    end
    @(posedge clk);
    #1;
    vin3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (vout3 !== (i == 2)) begin
        errors++;
        $display("FAIL rows3_valid cyc %0d got %b want %b", i, vout3, i == 2);
      end else if (i == 2 && res3 !== 16'h88EF) begin
        errors++;
        $display("FAIL rows3_result got %h want 88ef", res3);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_flight();
    drive(1'b1, 8'd11, 8'd13);
    drive(1'b1, 8'd21, 8'd23);
    drive(1'b1, 8'd31, 8'd33);
    vin = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (vout !== 1'b0 || res !== 16'd0) begin
      errors++;
      $display("FAIL flush_now v=%b res=%0d want 0/0", vout, res);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (vout !== 1'b0) begin
        errors++;
        $display("FAIL flush_stale cyc %0d got %b want 0", i, vout);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_enable();
    drive(1'b1, 8'd10, 8'd20);
    drive(1'b1, 8'd30, 8'd40);
    drive(1'b1, 8'd50, 8'd60);
    drive(1'b1, 8'd70, 8'd80);
    en  = 1'b0;
    vin = 1'b1;
    a   = 8'd9;
    b   = 8'd9;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (rdy_out !== 1'b0 || vout !== 1'b1) begin
        errors++;
        $display("FAIL en_freeze cyc %0d rdy=%b v=%b want 0/1",
                 i, rdy_out, vout);
      end
      checks++;
`ifdef UNSIGNED_ARRAY_MULTIPLIER_TRISTATE_OUT_EN
      if (res !== 16'bz) begin
        errors++;
        $display("FAIL en_result cyc %0d got %h want z", i, res);
      end
`else
      if (res !== 16'd200) begin
        errors++;
        $display("FAIL en_result cyc %0d got %0d want 200", i, res);
      end
`endif
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    drain("enable");
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    vin     = 1'b0;
    a       = '0;
    b       = '0;
    rdy_in  = 1'b1;
    vin3    = 1'b0;
    a3      = '0;
    b3      = '0;
    rdy_in3 = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_rows3();
    test_reset_flight();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
